if_fetch_buf: RTL and testbench

Instruction-fetch front end of the IF stage. Computes the next PC for the PC register, issues instruction-memory requests at the current PC, and pairs in-order responses with their PCs. Buffers up to DEPTH instructions toward decode with a valid/ready handshake, and squashes the stream on a redirect from EX (branch/jump).

---
 rtl/if_fetch_buf.sv | 134 +++++++++++++
 tb/tb_if_fetch_buf.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_buf.sv
// IF-stage fetch front end: next-PC select, in-order imem requests,
// PC/response pairing and a small decode-side instruction buffer.
module if_fetch_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic [DATA_WIDTH-1:0] nxt_pc_o,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
    output logic                  id_valid_o,
    input  logic                  id_ready_i,
    output logic [DATA_WIDTH-1:0] id_pc_o,
    output logic [DATA_WIDTH-1:0] id_instr_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_cnt;
    logic [PW-1:0] pq_wr;
    logic [PW-1:0] pq_rd;
    logic [PW-1:0] fq_wr;
    logic [PW-1:0] fq_rd;

    logic [DATA_WIDTH-1:0] pq_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] fq_pc    [DEPTH];
    logic [DATA_WIDTH-1:0] fq_instr [DEPTH];

    logic [SW-1:0] used;
    logic          credit;
    logic          pop;
    logic          fire;
    logic          rsp_live;
    logic          rsp_drop;
    logic          push;

    assign pop      = id_valid_o && id_ready_i;
    assign fire     = imem_req_valid_o && imem_req_ready_i;
    assign rsp_drop = imem_rsp_valid_i && (drop_cnt != '0);
    assign rsp_live = imem_rsp_valid_i && (drop_cnt == '0) && (out_cnt != '0);
    assign push     = rsp_live && !redirect_i && !rst_i;

    // A slot freed by this cycle's decode pop is reusable now,
    // which is what sustains one fetch per cycle at DEPTH=2.
    always_comb begin
        used = SW'(out_cnt) + SW'(drop_cnt) + SW'(fifo_cnt) - SW'(pop);
    end

    assign credit           = used < SW'(DEPTH);
    assign imem_req_valid_o = credit && !redirect_i && !rst_i;
    assign imem_addr_o      = pc_i;

    always_comb begin
        nxt_pc_o = pc_i;
        if (rst_i) begin
            nxt_pc_o = '0;
        end else if (redirect_i) begin
            nxt_pc_o = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
        end else if (fire) begin
            nxt_pc_o = pc_i + DATA_WIDTH'(4);
        end
    end

    assign id_valid_o = fifo_cnt != '0;
    assign id_pc_o    = id_valid_o ? fq_pc[fq_rd] : '0;
    assign id_instr_o = id_valid_o ? fq_instr[fq_rd] : '0;

    always_ff @(posedge clk_i) begin
        if (fire) begin
            pq_mem[pq_wr] <= pc_i;
        end
        if (push) begin
            fq_pc[fq_wr]    <= pq_mem[pq_rd];
            fq_instr[fq_wr] <= imem_rsp_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_cnt  <= '0;
            drop_cnt <= '0;
            fifo_cnt <= '0;
            pq_wr    <= '0;
            pq_rd    <= '0;
            fq_wr    <= '0;
            fq_rd    <= '0;
        end else if (redirect_i) begin
            // everything still in flight becomes stale
            out_cnt  <= '0;
            drop_cnt <= drop_cnt + out_cnt
                      - CW'(imem_rsp_valid_i
                            && ((drop_cnt != '0) || (out_cnt != '0)));
            fifo_cnt <= '0;
            pq_wr    <= '0;
            pq_rd    <= '0;
            fq_wr    <= '0;
            fq_rd    <= '0;
        end else begin
            if (fire) begin
                pq_wr <= pq_wr + PW'(1);
            end
            if (rsp_live) begin
                pq_rd <= pq_rd + PW'(1);
                fq_wr <= fq_wr + PW'(1);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (pop) begin
                fq_rd <= fq_rd + PW'(1);
            end
            out_cnt  <= out_cnt + CW'(fire) - CW'(rsp_live);
            fifo_cnt <= fifo_cnt + CW'(rsp_live) - CW'(pop);
        end
    end

    a_rsp_orphan: assert property (@(posedge clk_i) disable iff (rst_i)
        !(imem_rsp_valid_i && out_cnt == '0 && drop_cnt == '0));

    a_fifo_ovf: assert property (@(posedge clk_i) disable iff (rst_i)
        !(rsp_live && fifo_cnt == CW'(DEPTH)));

endmodule

// File: tb/tb_if_fetch_buf.sv
// Bench for if_fetch_buf: directed scenarios then random traffic,
// all checked against a queue-level model of the fetch stream.
module tb_if_fetch_buf;

    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [DW-1:0] pc_i;
    logic [DW-1:0] nxt_pc_o;
    logic          redirect_i;
    logic [DW-1:0] redirect_pc_i;
    logic          imem_req_valid_o;
    logic          imem_req_ready_i;
    logic [DW-1:0] imem_addr_o;
    logic          imem_rsp_valid_i;
    logic [DW-1:0] imem_rsp_data_i;
    logic          id_valid_o;
    logic          id_ready_i;
    logic [DW-1:0] id_pc_o;
    logic [DW-1:0] id_instr_o;

    always #5 clk = ~clk;

    if_fetch_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .pc_i            (pc_i),
        .nxt_pc_o        (nxt_pc_o),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .imem_req_valid_o(imem_req_valid_o),
        .imem_req_ready_i(imem_req_ready_i),
        .imem_addr_o     (imem_addr_o),
        .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i (imem_rsp_data_i),
        .id_valid_o      (id_valid_o),
        .id_ready_i      (id_ready_i),
        .id_pc_o         (id_pc_o),
        .id_instr_o      (id_instr_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rel    = 0;
    int lat    = 1;
    int last_due = 0;
    int stale_n  = 0;

    logic [31:0] pc_reg = 32'h0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_q[$];
    int          mem_due[$];
    logic [31:0] fire_log[$];
    logic [31:0] pop_log[$];
    int          pop_cyc[$];

    logic        drv_rst   = 1'b1;
    logic        drv_redir = 1'b0;
    logic [31:0] drv_rpc   = 32'h0;
    logic        drv_rrdy  = 1'b1;
    logic        drv_irdy  = 1'b1;

    logic [31:0] last_nxt;
    logic [31:0] last_addr;
    logic [31:0] last_idpc;
    logic [31:0] last_idins;
    logic        last_reqv;
    logic        last_idv;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        fire_log.delete();
        pop_log.delete();
        pop_cyc.delete();
    endtask

    task automatic cycle();
        logic        rsp;
        logic [31:0] rsp_a;
        int          live_pend;
        int          buffered;
        int          due;
        logic        e_idv;
        logic        e_pop;
        logic        e_reqv;
        logic        e_fire;
        logic [31:0] e_nxt;
        @(negedge clk);
        rsp   = (mem_q.size() > 0) && (mem_due[0] <= cyc);
        rsp_a = rsp ? mem_q[0] : 32'h0;
        rst_i            = drv_rst;
        redirect_i       = drv_redir;
        redirect_pc_i    = drv_rpc;
        imem_req_ready_i = drv_rrdy;
        id_ready_i       = drv_irdy;
        pc_i             = pc_reg;
        imem_rsp_valid_i = rsp;
        imem_rsp_data_i  = rsp ? ins(rsp_a) : 32'h0;
        #1;
        live_pend = mem_q.size() - stale_n;
        buffered  = exp_q.size() - live_pend;
        e_idv  = !drv_rst && (buffered > 0);
        e_pop  = e_idv && drv_irdy;
        e_reqv = !drv_rst && !drv_redir
               && (exp_q.size() + stale_n - int'(e_pop) < DEPTH);
        e_fire = e_reqv && drv_rrdy;
        if (drv_rst)        e_nxt = 32'h0;
        else if (drv_redir) e_nxt = {drv_rpc[31:2], 2'b00};
        else if (e_fire)    e_nxt = pc_reg + 32'd4;
        else                e_nxt = pc_reg;
        chk("req_valid", {31'b0, imem_req_valid_o}, {31'b0, e_reqv});
        chk("nxt_pc", nxt_pc_o, e_nxt);
        if (!drv_rst) begin
            chk("id_valid", {31'b0, id_valid_o}, {31'b0, e_idv});
            if (e_idv) begin
                chk("id_pc", id_pc_o, exp_q[0]);
                chk("id_instr", id_instr_o, ins(exp_q[0]));
            end
            if (e_reqv) chk("imem_addr", imem_addr_o, pc_reg);
        end
        last_nxt   = nxt_pc_o;
        last_addr  = imem_addr_o;
        last_reqv  = imem_req_valid_o;
        last_idv   = id_valid_o;
        last_idpc  = id_pc_o;
        last_idins = id_instr_o;
        @(posedge clk);
        if (drv_rst) begin
            exp_q.delete();
            mem_q.delete();
            mem_due.delete();
            stale_n  = 0;
            last_due = 0;
            pc_reg   = 32'h0;
            rel      = 0;
        end else begin
            if (rsp) begin
                void'(mem_q.pop_front());
                void'(mem_due.pop_front());
            end
            if (drv_redir) stale_n = mem_q.size();
            else if (rsp && stale_n > 0) stale_n--;
            if (e_pop) begin
                pop_log.push_back(exp_q[0]);
                pop_cyc.push_back(rel);
                void'(exp_q.pop_front());
            end
            if (drv_redir) exp_q.delete();
            if (e_fire) begin
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                exp_q.push_back(pc_reg);
                mem_q.push_back(pc_reg);
                mem_due.push_back(due);
                fire_log.push_back(pc_reg);
            end
            pc_reg = e_nxt;
            rel++;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // reset, then back-to-back fetch with 1-cycle memory
        drv_rst = 1'b1; drv_irdy = 1'b1; drv_rrdy = 1'b1; lat = 1;
        run(2);
        drv_rst = 1'b0;
        clear_logs();
        cycle();
        chk("rst_idv", {31'b0, last_idv}, 32'h0);
        chk("rst_idpc", last_idpc, 32'h0);
        chk("rst_idins", last_idins, 32'h0);
        chk("first_req", {31'b0, last_reqv}, 32'h1);
        chk("first_addr", last_addr, 32'h0);
        run(5);
        chk("tput_n", pop_log.size() >= 3 ? 32'd3 : 32'(pop_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < pop_log.size(); i++) begin
            chk("tput_pc", pop_log[i], 32'(4 * i));
            chk("tput_cyc", 32'(pop_cyc[i]), 32'(2 + i));
        end

        // decode stall: only DEPTH requests go out
        drv_rst = 1'b1; cycle(); drv_rst = 1'b0;
        drv_irdy = 1'b0;
        clear_logs();
        run(5);
        chk("stall_reqs", 32'(fire_log.size()), 32'd2);
        chk("stall_idpc", last_idpc, 32'h0);
        chk("stall_nxt", last_nxt, 32'h8);
        chk("stall_pc", pc_i, 32'h8);
        drv_irdy = 1'b1;
        clear_logs();
        run(8);
        for (int i = 0; i < 4 && i < pop_log.size(); i++)
            chk("stall_resume", pop_log[i], 32'(4 * i));

        // redirect with two slow responses outstanding
        drv_rst = 1'b1; cycle(); drv_rst = 1'b0;
        lat = 5;
        drv_redir = 1'b1; drv_rpc = 32'h10; cycle(); drv_redir = 1'b0;
        clear_logs();
        run(2);
        chk("redir_n", 32'(fire_log.size()), 32'd2);
        for (int i = 0; i < 2 && i < fire_log.size(); i++)
            chk("redir_old", fire_log[i], 32'h10 + 32'(4 * i));
        drv_redir = 1'b1; drv_rpc = 32'h103; cycle(); drv_redir = 1'b0;
        chk("redir_noreq", {31'b0, last_reqv}, 32'h0);
        chk("redir_nxt", last_nxt, 32'h100);
        clear_logs();
        lat = 1;
        run(12);
        chk("redir_addr", fire_log.size() > 0 ? fire_log[0] : 32'hDEAD, 32'h100);
        chk("redir_dec", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD, 32'h100);

        // redirect colliding with a stale response and a decode pop
        drv_rst = 1'b1; cycle(); drv_rst = 1'b0;
        run(6);
        drv_redir = 1'b1; drv_rpc = 32'h2000; cycle(); drv_redir = 1'b0;
        clear_logs();
        run(10);
        chk("coll_n", pop_log.size() >= 3 ? 32'd3 : 32'(pop_log.size()), 32'd3);
        if (pop_log.size() >= 3) begin
            chk("coll_pc", pop_log[0], 32'h2000);
            chk("coll_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
            chk("coll_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
        end

        // PC wrap at the top of the address space
        drv_redir = 1'b1; drv_rpc = 32'hFFFF_FFFE; cycle(); drv_redir = 1'b0;
        clear_logs();
        cycle();
        chk("wrap_addr", fire_log.size() > 0 ? fire_log[0] : 32'hDEAD, 32'hFFFF_FFFC);
        chk("wrap_nxt", last_nxt, 32'h0);
        run(4);

        // reset while the buffer is full
        drv_irdy = 1'b0;
        run(4);
        drv_rst = 1'b1; cycle();
        chk("mrst_reqv", {31'b0, last_reqv}, 32'h0);
        chk("mrst_nxt", last_nxt, 32'h0);
        drv_rst = 1'b0;
        cycle();
        chk("mrst_idv", {31'b0, last_idv}, 32'h0);
        chk("mrst_idpc", last_idpc, 32'h0);
        chk("mrst_addr", last_addr, 32'h0);
        drv_irdy = 1'b1;

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            drv_rst   = ($urandom % 250) == 0;
            drv_redir = !drv_rst && (($urandom % 20) == 0);
            drv_rpc   = $urandom;
            drv_rrdy  = ($urandom % 4) != 0;
            drv_irdy  = ($urandom % 3) != 0;
            lat       = 1 + int'($urandom % 4);
            cycle();
        end
        drv_rst = 1'b0; drv_redir = 1'b0; drv_rrdy = 1'b1; drv_irdy = 1'b1;
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
